hazard_ctrl_mc: RTL

Next-generation hazard/forwarding controller for the 5-stage RV32 pipeline. It keeps EXE/MEM forwarding and load-use stalling, now qualified by RegWrite. It adds two stateful stall sources: a multi-cycle EXE unit (mul/div) with parametrised latency, and a variable-latency memory port with a ready handshake and timeout. It sits beside the pipeline registers and drives their enable/flush pins plus the operand-forwarding muxes.

---
 rtl/hazard_ctrl_mc.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for the 5-stage RV32 pipeline: forwarding, load-use,
// multi-cycle EXE and variable-latency memory stalls. Optional perf counters: HAZ_PERF_CNT_EN.
module hazard_ctrl_mc #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned MEM_TO = 255
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Branch_ID,
    input  logic              rs1use_ID,
    input  logic              rs2use_ID,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic [REG_AW-1:0] rd_EXE,
    input  logic [REG_AW-1:0] rd_MEM,
    input  logic [REG_AW-1:0] rs2_EXE,
    input  logic              RegWrite_EXE,
    input  logic              RegWrite_MEM,
    input  logic              DatatoReg_EXE,
    input  logic              DatatoReg_MEM,
    input  logic              mc_op_EXE,
    input  logic              MemAccess_MEM,
    input  logic              mem_ready,
    output logic              PC_EN_IF,
    output logic              reg_FD_EN,
    output logic              reg_DE_EN,
    output logic              reg_EM_EN,
    output logic              reg_MW_EN,
    output logic              reg_FD_flush,
    output logic              reg_DE_flush,
    output logic              reg_EM_flush,
    output logic              reg_MW_flush,
    output logic [1:0]        forward_ctrl_A,
    output logic [1:0]        forward_ctrl_B,
    output logic              forward_ctrl_ls,
    output logic              mc_go,
    output logic              mem_err,
    output logic [1:0]        state_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_lu,
    output logic [CNT_W-1:0]  perf_mc,
    output logic [CNT_W-1:0]  perf_mem
`endif
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MC_WAIT  = 2'd1;
    localparam logic [1:0] S_MEM_WAIT = 2'd2;

    localparam int unsigned    WCW       = $clog2(MEM_TO + 2);
    localparam logic [7:0]     MC_INIT   = 8'(MC_LAT - 2);
    localparam logic [WCW-1:0] WCNT_MAX  = WCW'(MEM_TO);
    localparam logic [WCW-1:0] WCNT_LAST = WCW'(MEM_TO - 1);

    logic [1:0]     state;
    logic [1:0]     ret;
    logic [7:0]     cnt;
    logic [WCW-1:0] wcnt;

    logic hit_e1, hit_e2, hit_m1, hit_m2;
    logic load_use, mem_stall, mc_stall;

    always_comb begin
        hit_e1 = rs1use_ID & (rs1_ID != '0) & (rs1_ID == rd_EXE) & RegWrite_EXE;
        hit_e2 = rs2use_ID & (rs2_ID != '0) & (rs2_ID == rd_EXE) & RegWrite_EXE;
        hit_m1 = rs1use_ID & (rs1_ID != '0) & (rs1_ID == rd_MEM) & RegWrite_MEM;
        hit_m2 = rs2use_ID & (rs2_ID != '0) & (rs2_ID == rd_MEM) & RegWrite_MEM;
    end

    // A load in EXE cannot forward; it falls through to the MEM match (or stalls).
    function automatic logic [1:0] fwd_sel(input logic he, input logic hm,
                                           input logic ld_exe, input logic ld_mem);
        if (he && !ld_exe)
            return 2'b01;
        else if (hm)
            return ld_mem ? 2'b11 : 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        load_use = (hit_e1 | hit_e2) & DatatoReg_EXE;
        if (state == S_MEM_WAIT)
            mem_stall = ~mem_ready;
        else
            mem_stall = MemAccess_MEM & ~mem_ready;
        mc_stall = ((state == S_RUN) & mc_op_EXE & ~mem_stall) |
                   ((state == S_MC_WAIT) & (cnt != '0));
    end

    always_comb begin
        PC_EN_IF        = 1'b1;
        reg_FD_EN       = 1'b1;
        reg_DE_EN       = 1'b1;
        reg_EM_EN       = 1'b1;
        reg_MW_EN       = 1'b1;
        reg_FD_flush    = 1'b0;
        reg_DE_flush    = 1'b0;
        reg_EM_flush    = 1'b0;
        reg_MW_flush    = 1'b0;
        forward_ctrl_A  = fwd_sel(hit_e1, hit_m1, DatatoReg_EXE, DatatoReg_MEM);
        forward_ctrl_B  = fwd_sel(hit_e2, hit_m2, DatatoReg_EXE, DatatoReg_MEM);
        forward_ctrl_ls = DatatoReg_MEM & RegWrite_MEM & (rd_MEM == rs2_EXE) &
                          (rs2_EXE != '0);
        mc_go           = (state == S_RUN) & mc_op_EXE & ~mem_stall;

        if (mem_stall) begin
            PC_EN_IF     = 1'b0;
            reg_FD_EN    = 1'b0;
            reg_DE_EN    = 1'b0;
            reg_EM_EN    = 1'b0;
            reg_MW_flush = 1'b1;
        end else if (mc_stall) begin
            PC_EN_IF     = 1'b0;
            reg_FD_EN    = 1'b0;
            reg_DE_EN    = 1'b0;
            reg_EM_flush = 1'b1;
        end else if (load_use) begin
            PC_EN_IF     = 1'b0;
            reg_FD_EN    = 1'b0;
            reg_DE_flush = 1'b1;
        end else begin
            reg_FD_flush = Branch_ID;
        end

        if (rst) begin
            PC_EN_IF        = 1'b1;
            reg_FD_EN       = 1'b1;
            reg_DE_EN       = 1'b1;
            reg_EM_EN       = 1'b1;
            reg_MW_EN       = 1'b1;
            reg_FD_flush    = 1'b1;
            reg_DE_flush    = 1'b1;
            reg_EM_flush    = 1'b1;
            reg_MW_flush    = 1'b1;
            forward_ctrl_A  = 2'b00;
            forward_ctrl_B  = 2'b00;
            forward_ctrl_ls = 1'b0;
            mc_go           = 1'b0;
        end
    end

    // cnt stays frozen while a memory stall interrupts MC_WAIT; ret remembers where to resume.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_RUN;
            ret     <= S_RUN;
            cnt     <= '0;
            wcnt    <= '0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (mem_stall) begin
                        state <= S_MEM_WAIT;
                        ret   <= S_RUN;
                        wcnt  <= '0;
                    end else if (mc_op_EXE) begin
                        cnt   <= MC_INIT;
                        state <= S_MC_WAIT;
                    end
                end
                S_MC_WAIT: begin
                    if (mem_stall) begin
                        state <= S_MEM_WAIT;
                        ret   <= S_MC_WAIT;
                        wcnt  <= '0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_ready) begin
                        state <= ret;
                        wcnt  <= '0;
                    end else begin
                        if (wcnt != WCNT_MAX)
                            wcnt <= wcnt + 1'b1;
                        if (wcnt == WCNT_LAST)
                            mem_err <= 1'b1;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    assign state_o = state;

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu  <= '0;
            perf_mc  <= '0;
            perf_mem <= '0;
        end else if (mem_stall) begin
            if (perf_mem != '1)
                perf_mem <= perf_mem + 1'b1;
        end else if (mc_stall) begin
            if (perf_mc != '1)
                perf_mc <= perf_mc + 1'b1;
        end else if (load_use) begin
            if (perf_lu != '1)
                perf_lu <= perf_lu + 1'b1;
        end
    end
`endif

endmodule
